mdio_master: RTL

- MDIO (IEEE 802.3 clause 22) management master that generates `mdio_mdc` and serialises read/write frames to the Alaska PHY on the KC705 GMII port.
- Sits between the FTop control plane (request/response handshake) and the board `mdio_mdc`/`mdio_mdd` pins.
- The top level builds the inout `mdio_mdd` from `mdio_out`/`mdio_oe`/`mdio_in` with an IOBUF.
- Single clock `sys0_clk`; reset is `sys0_rst`, synchronous and active-high.

---
 rtl/mdio_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - MDIO clause 22 management master with request/response handshake
module mdio_master #(
  parameter int MDC_HALF    = 40,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        sys0_clk,
  input  logic        sys0_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdio_mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  localparam int HW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(MDC_HALF - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  state_t        state, next_state;
  logic          lead;       // cycle 0 after accept: busy but frame not yet started
  logic [HW-1:0] half_cnt;
  logic          mdc_q;
  logic [5:0]    bit_cnt;
  logic [5:0]    reload;
  logic          is_write;
  logic [31:0]   tx_sr;      // ST, OP, PHYAD, REGAD, TA, DATA; MSB goes out first
  logic [15:0]   rx_sr;
  logic          in_frame;
  logic          half_end;
  logic          rise;
  logic          bit_end;
  logic          last_bit;

  assign in_frame  = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
  assign half_end  = !lead && (half_cnt == HALF_LAST);
  assign rise      = half_end && !mdc_q;
  assign bit_end   = half_end && mdc_q;
  assign last_bit  = bit_end && (bit_cnt == 6'd0);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign mdio_mdc  = mdc_q;

  // State register
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic and MDIO pin drive derived from the current frame position
  always_comb begin
    next_state = state;
    mdio_oe    = 1'b0;
    mdio_out   = 1'b1;
    case (state)
      IDLE: if (req_valid) next_state = PREAMBLE_EN ? PRE : HDR;
      PRE: begin
        mdio_oe = !lead;
        if (last_bit) next_state = HDR;
      end
      HDR: begin
        mdio_oe  = !lead;
        mdio_out = lead ? 1'b1 : tx_sr[31];
        if (last_bit) next_state = TA;
      end
      TA: begin
        mdio_oe  = is_write;
        mdio_out = is_write ? tx_sr[31] : 1'b1;
        if (last_bit) next_state = DATA;
      end
      DATA: begin
        mdio_oe  = is_write;
        mdio_out = is_write ? tx_sr[31] : 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit count to load when leaving the current state
  always_comb begin
    reload = 6'd0;
    case (state)
      PRE:     reload = 6'd13;
      HDR:     reload = 6'd1;
      TA:      reload = 6'd15;
      default: reload = 6'd0;
    endcase
  end

  // Frame datapath: MDC divider, bit counter, shift registers and response capture
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      lead      <= 1'b0;
      half_cnt  <= '0;
      mdc_q     <= 1'b0;
      bit_cnt   <= 6'd0;
      is_write  <= 1'b0;
      tx_sr     <= 32'h0;
      rx_sr     <= 16'h0;
      rsp_rdata <= 16'h0;
      rsp_err   <= 1'b0;
    end else if (state == IDLE) begin
      half_cnt <= '0;
      mdc_q    <= 1'b0;
      if (req_valid) begin
        lead     <= 1'b1;
        bit_cnt  <= PREAMBLE_EN ? 6'd31 : 6'd13;
        is_write <= req_write;
        tx_sr    <= {2'b01, (req_write ? 2'b01 : 2'b10), req_phyad, req_regad,
                     2'b10, (req_write ? req_wdata : 16'h0)};
        rsp_err  <= 1'b0;
      end
    end else if (in_frame) begin
      if (lead) begin
        lead <= 1'b0;
      end else begin
        if (half_end) begin
          half_cnt <= '0;
          mdc_q    <= ~mdc_q;
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
        // Reads sample the pin on the MDC rising edge
        if (rise && !is_write) begin
          if ((state == TA) && (bit_cnt == 6'd0) && mdio_in) rsp_err <= 1'b1;
          if (state == DATA) rx_sr <= {rx_sr[14:0], mdio_in};
        end
        if (bit_end) begin
          if (state != PRE) tx_sr <= {tx_sr[30:0], 1'b0};
          bit_cnt <= (bit_cnt == 6'd0) ? reload : bit_cnt - 6'd1;
          if (last_bit && (state == DATA)) rsp_rdata <= is_write ? 16'h0 : rx_sr;
        end
      end
    end
  end

endmodule
